// File: rtl/vib_uart_pkg.sv
// Shared FSM encoding, default line-rate constants and a constant clog2 for the UART drain stage.
// Purely declarative; no timing or backpressure of its own.
package vib_uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_BAUD        = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Loadable down-counter that stops at zero; tc is high while the count is zero (registered count, combinational tc).
// No backpressure: load wins over counting on any cycle.
module baud_counter #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WIDTH        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO word (RD_HOLD-cycle strobe, one idle cycle) and sends it as UART 8N1, LSB first; tx falls RD_HOLD+1 cycles after the pop decision.
// No backpressure from the line: new pops are only taken in IDLE while enable is high and the FIFO is non-empty.
module fifo_uart_tx
  import vib_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD,
  parameter int DATA_WIDTH  = 8,
  parameter int RD_HOLD     = 2
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_MAX      = (CLKS_PER_BIT > RD_HOLD) ? CLKS_PER_BIT : RD_HOLD;
  localparam int CW           = clog2(CNT_MAX);
  localparam int IW           = (DATA_WIDTH > 1) ? clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RD_HOLD - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

  if (RD_HOLD < 1) begin : g_bad_hold
    $error("RD_HOLD must be >= 1");
  end

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [IW-1:0]         bit_idx;
  logic                  go;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_val;
  logic [CW-1:0]         count;
  logic                  tc;

  // The counter reloads on the same edge the FSM changes state, so every state starts a fresh period.
  always_comb begin
    go        = (state == IDLE) && enable && !fifo_empty;
    cnt_load  = go || (state == LOAD) || ((state != IDLE) && tc);
    cnt_val   = (state == IDLE) ? HOLD_LOAD : BIT_LOAD;
    shreg_nxt = shreg >> 1;
  end

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .WIDTH        (CW)
  ) u_baud (
    .clk      (sys_clock),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (count),
    .tc       (tc)
  );

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state      <= READ;
          fifo_rd_en <= 1'b1;
          busy       <= 1'b1;
        end
        READ: if (tc) begin
          state      <= LOAD;
          fifo_rd_en <= 1'b0;
        end
        // Strobe has been low one cycle; the FIFO's d_out still holds the popped word.
        LOAD: begin
          state <= START;
          shreg <= fifo_data;
          tx    <= 1'b0;
        end
        START: if (tc) begin
          state   <= DATA;
          tx      <= shreg[0];
          bit_idx <= '0;
        end
        DATA: if (tc) begin
          if (bit_idx == LAST_BIT) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + IW'(1);
            shreg   <= shreg_nxt;
            tx      <= shreg_nxt[0];
          end
        end
        STOP: begin
          if (count == CW'(1)) byte_done <= 1'b1;
          if (tc) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLKS_PER_BIT=4, RD_HOLD=2: behavioural FIFO, line decoder and a queue of expected line patterns.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;

  fifo_uart_tx #(
    .CLK_FREQ_HZ (16),
    .BAUD        (4),
    .DATA_WIDTH  (8),
    .RD_HOLD     (2)
  ) dut (
    .sys_clock  (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] fifo_q[$];
  logic [9:0] sb[$];
  logic       toggle_mode = 1'b0;
  logic       rd_prev = 1'b0;

  // Monitor state
  logic in_frame = 1'b0;
  int   mon_idx = 0;
  logic smp[0:39];
  logic bd_early = 1'b0;
  logic bd_last = 1'b0;
  int   frames_seen = 0;
  int   gap_cnt = 0;
  int   last_gap = 0;
  int   last_lat = 0;
  int   rd_rise_cyc = 0;
  int   cur_len = 0;
  int   last_len = 0;
  int   rd_pulses = 0;
  int   bad_len = 0;
  int   bd_total = 0;

  function automatic logic [9:0] line_of(input logic [7:0] b);
    logic [9:0] l;
    l[9] = 1'b0;
    for (int i = 0; i < 8; i++) l[8-i] = b[i];
    l[0] = 1'b1;
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_frame();
    logic       shape_ok;
    logic [9:0] line;
    shape_ok = 1'b1;
    for (int g = 0; g < 10; g++) begin
      line[9-g] = smp[4*g];
      for (int k = 1; k < 4; k++)
        if (smp[4*g+k] !== smp[4*g]) shape_ok = 1'b0;
    end
    chk("frame_shape", {31'd0, shape_ok}, 32'd1);
    chk("byte_done_at_40", {30'd0, bd_early, bd_last}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got line %b with no expected entry", line);
    end else begin
      chk("line", {22'd0, line}, {22'd0, sb.pop_front()});
    end
    frames_seen++;
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: d_out loads while the strobe is high, pointer advances on its falling edge.
  always @(negedge clk) begin
    if (toggle_mode) fifo_data = fifo_data + 8'h35;
    else if (fifo_rd_en && fifo_q.size() > 0) fifo_data = fifo_q[0];
    if (!fifo_rd_en && rd_prev) begin
      if (toggle_mode) sb.push_back(line_of(fifo_data));
      if (fifo_q.size() > 0) fifo_q.delete(0);
    end
    rd_prev = fifo_rd_en;
    fifo_empty = (fifo_q.size() == 0);
  end

  // Line / strobe monitor
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      cur_len  = 0;
      gap_cnt  = 0;
    end else begin
      if (fifo_rd_en) begin
        if (cur_len == 0) rd_rise_cyc = cyc;
        cur_len++;
      end else if (cur_len > 0) begin
        last_len = cur_len;
        rd_pulses++;
        if (cur_len != 2) bad_len++;
        cur_len = 0;
      end
      if (byte_done) bd_total++;
      if (!in_frame) begin
        if (tx == 1'b0) begin
          in_frame = 1'b1;
          smp[0]   = 1'b0;
          mon_idx  = 1;
          last_gap = gap_cnt;
          last_lat = cyc - rd_rise_cyc;
          bd_early = byte_done;
        end else begin
          gap_cnt++;
        end
      end else begin
        smp[mon_idx] = tx;
        if (mon_idx == 39) begin
          bd_last = byte_done;
          finish_frame();
          in_frame = 1'b0;
          gap_cnt  = 0;
        end else begin
          if (byte_done) bd_early = 1'b1;
        end
        mon_idx++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_seen < target) begin
      checks++;
      errors++;
      $display("FAIL timeout_frames: seen %0d need %0d", frames_seen, target);
    end
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n;
    n = 0;
    while (!(in_frame && mon_idx >= target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(in_frame && mon_idx >= target)) begin
      checks++;
      errors++;
      $display("FAIL timeout_idx: idx %0d need %0d", mon_idx, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   f0, p0, c0, bd0;
    vecs[0] = '{data: 8'hA5, line: 10'b0101001011};
    vecs[1] = '{data: 8'h01, line: 10'b0100000001};
    vecs[2] = '{data: 8'h80, line: 10'b0000000011};
    vecs[3] = '{data: 8'h5A, line: 10'b0010110101};

    // Async reset between clock edges
    #2 reset = 1'b1;
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_byte_done", {31'd0, byte_done}, 32'd0);
    tick(2);
    reset  = 1'b0;
    enable = 1'b1;
    tick(2);

    // Single frames from the table
    for (int i = 0; i < 4; i++) begin
      f0 = frames_seen;
      p0 = rd_pulses;
      fifo_q.push_back(vecs[i].data);
      sb.push_back(vecs[i].line);
      wait_frames(f0 + 1, 200);
      tick(2);
      chk("rd_pulse_count", rd_pulses - p0, 1);
      chk("rd_pulse_len", last_len, 2);
      chk("rd_to_tx_latency", last_lat, 3);
      chk("idle_after_frame", {31'd0, busy}, 32'd0);
    end

    // Back-to-back 0x00, 0xFF
    f0 = frames_seen;
    p0 = rd_pulses;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    sb.push_back(10'b0000000001);
    sb.push_back(10'b0111111111);
    wait_frames(f0 + 2, 300);
    chk("b2b_gap", last_gap, 4);
    tick(30);
    chk("b2b_pulses", rd_pulses - p0, 2);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // enable dropped mid data bit 3
    f0 = frames_seen;
    p0 = rd_pulses;
    fifo_q.push_back(8'h3C);
    sb.push_back(10'b0001111001);
    wait_idx(18, 100);
    enable = 1'b0;
    fifo_q.push_back(8'h77);
    sb.push_back(line_of(8'h77));
    wait_frames(f0 + 1, 200);
    tick(40);
    chk("no_pop_while_disabled", rd_pulses - p0, 1);
    chk("disabled_frames", frames_seen - f0, 1);
    chk("disabled_busy", {31'd0, busy}, 32'd0);
    c0 = cyc;
    enable = 1'b1;
    wait_frames(f0 + 2, 200);
    chk("pop_after_enable", rd_rise_cyc - c0, 1);

    // Reset during DATA
    f0 = frames_seen;
    tick(2);
    fifo_q.push_back(8'hC3);
    sb.push_back(line_of(8'hC3));
    wait_idx(12, 100);
    bd0 = bd_total;
    reset = 1'b1;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    sb.delete();
    tick(3);
    fifo_q.push_back(8'h96);
    sb.push_back(line_of(8'h96));
    c0 = cyc;
    reset = 1'b0;
    wait_frames(f0 + 1, 200);
    chk("pop_after_reset", rd_rise_cyc - c0, 1);
    chk("no_byte_done_on_abort", bd_total - bd0, 1);
    tick(4);

    // fifo_data changing every cycle: only the LOAD-edge value may be sent
    f0 = frames_seen;
    toggle_mode = 1'b1;
    fifo_q.push_back(8'h00);
    wait_frames(f0 + 1, 200);
    toggle_mode = 1'b0;
    tick(4);

    chk("rd_len_all", bad_len, 0);
    chk("byte_done_total", bd_total, frames_seen);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the sample FIFO. It pops bytes from the FIFO read port whenever the FIFO is non-empty and transmission is enabled, then serializes each byte as UART 8N1, LSB first, toward the host link. It drives the FIFO's level-sensitive read strobe; the FIFO advances its read pointer on the falling edge of that strobe.

Parameters:
CLK_FREQ_HZ, 50000000, sys_clock frequency in Hz.
BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide), must be >= 2; otherwise elaboration error.
DATA_WIDTH, 8, FIFO word and UART payload width.
RD_HOLD, 2, cycles fifo_rd_en is held high per pop; must be >= 1. Covers RAM read latency plus the FIFO output register.

Ports:
sys_clock  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  high = allow new pops; sampled only in IDLE.
fifo_empty  in  1  FIFO isEmpty flag.
fifo_data  in  DATA_WIDTH  FIFO registered d_out.
fifo_rd_en  out  1  FIFO read strobe, registered.
tx  out  1  UART serial line, registered, idle high.
busy  out  1  high in every state except IDLE.
byte_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values (async): tx=1, fifo_rd_en=0, busy=0, byte_done=0, state=IDLE, all counters=0, shift register=0.
- States:
  - IDLE -> READ when enable & ~fifo_empty.
  - READ: fifo_rd_en=1 for RAM_HOLD... specifically for exactly RD_HOLD cycles -> LOAD.
  - LOAD: fifo_rd_en=0 for 1 cycle, so the FIFO sees the falling edge and increments -> START.
  - START: capture fifo_data into the shift register on entry; tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: DATA_WIDTH bits, LSB first, each bit CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; byte_done pulses on the last cycle -> IDLE.
- Latency: let edge E be the first posedge where IDLE sees enable & ~fifo_empty.
  - fifo_rd_en is high during cycles E..E+RD_HOLD-1.
  - tx falls at edge E+RD_HOLD+1.
  - The byte occupies 10*CLKS_PER_BIT cycles of line time.
  - Back-to-back bytes therefore have an inter-frame idle gap of RD_HOLD+2 cycles.
- Bit timing: a single down-counter (0..CLKS_PER_BIT-1) plus a bit index counter of clog2(DATA_WIDTH) bits. Both reload on every state entry. There is no drift across frames.
- fifo_empty is sampled only in IDLE. By then the FIFO pointer update from the previous pop has settled (at least CLKS_PER_BIT cycles have elapsed).
- Empty in IDLE: no strobe is issued. A FIFO underflow read is never generated.
- enable deasserted mid-byte: the current frame completes normally, then the block stays in IDLE.
- enable re-asserted: a pop starts on the next IDLE cycle with ~fifo_empty.
- fifo_data is sampled only at LOAD -> START. Changes at any other time are ignored.
- Reset mid-operation: tx returns high immediately (async). The partial frame is aborted and the popped byte is lost. No byte_done is emitted.
- byte_done and busy:
  - busy is high from the READ entry edge through the last STOP cycle.
  - busy falls on the same edge as IDLE entry.
  - byte_done is never asserted outside STOP.

Decomposition:
- Shared package (vib_uart_pkg): state encoding constants (IDLE, READ, LOAD, START, DATA, STOP), the clog2 function, and the default CLK_FREQ_HZ/BAUD constants.
- One natural sub-module: baud_counter (loadable down-counter with terminal-count output, parameter CLKS_PER_BIT). It is instantiated once and reloaded on each state entry.
- The FSM, shift register, and bit index stay in fifo_uart_tx.

Test Plan:
All scenarios use CLK_FREQ_HZ=16, BAUD=4 (CLKS_PER_BIT=4), RD_HOLD=2.
1. Reset: assert reset asynchronously mid-cycle -> tx=1, fifo_rd_en=0, busy=0 immediately, before the next clock edge.
2. Single byte 0xA5, fifo_empty falls while enable=1:
   - fifo_rd_en high for exactly 2 cycles.
   - tx low 3 cycles after the strobe starts.
   - Line sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
   - byte_done pulses once on cycle 40 of the frame.
3. FIFO holding 0x00 and 0xFF:
   - Two frames; the idle-high gap between them is exactly 4 cycles.
   - Exactly two fifo_rd_en pulses, then fifo_empty=1 and no further strobes.
4. enable dropped at the middle of data bit 3 of 0x3C:
   - The frame completes intact.
   - No new fifo_rd_en while enable=0, even with fifo_empty=0.
5. Reset asserted during the DATA state:
   - tx=1 at once, no byte_done.
   - After release with fifo_empty=0 and enable=1, a new pop begins on the first IDLE cycle.
6. fifo_data toggled every cycle except at the LOAD edge -> the transmitted byte equals the value present at the LOAD edge.
